// File: rtl/manejo_ventana_deslizante.sv
// Sliding-window row manager: fetches image rows over a request/complete handshake and keeps
// the last FILAS_VENTANA rows of the current column, walking columns left to right.
module manejo_ventana_deslizante #(
  parameter int unsigned BITS_FILA          = 64,
  parameter int unsigned FILAS_VENTANA      = 5,
  parameter int unsigned FILAS_IMAGEN       = 256,
  parameter int unsigned COLUMNAS_IMAGEN    = 32,
  parameter int unsigned BITS_DIRECCION_MEM = 17,
  parameter int unsigned DIRECCION_INICIAL  = 0,
  parameter int unsigned SUMA_SIG_FILA      = 256,
  parameter int unsigned SUMA_SIG_COLUMNA   = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               iniciar_proceso,
  input  logic                               actualizar_ventana,
  input  logic [BITS_FILA-1:0]               datos_mem,
  input  logic                               transaccion_mem_completada,
  output logic [FILAS_VENTANA*BITS_FILA-1:0] ventana,
  output logic                               leer_mem,
  output logic                               liberar_bus_mem,
  output logic [BITS_DIRECCION_MEM-1:0]      direccion_mem,
  output logic                               ventana_lista,
  output logic                               fin_columna,
  output logic                               fin_imagen
);

  localparam int unsigned BitsCarg = $clog2(FILAS_VENTANA + 1);
  localparam int unsigned BitsLeid = $clog2(FILAS_IMAGEN + 1);
  localparam int unsigned BitsCol  = $clog2(COLUMNAS_IMAGEN + 1);
  localparam int unsigned BitsVen  = FILAS_VENTANA * BITS_FILA;

  localparam logic [BitsCarg-1:0]           MaxCarg  = BitsCarg'(FILAS_VENTANA);
  localparam logic [BitsLeid-1:0]           MaxLeid  = BitsLeid'(FILAS_IMAGEN);
  localparam logic [BitsCol-1:0]            UltCol   = BitsCol'(COLUMNAS_IMAGEN - 1);
  localparam logic [BITS_DIRECCION_MEM-1:0] DirIni   = BITS_DIRECCION_MEM'(DIRECCION_INICIAL);
  localparam logic [BITS_DIRECCION_MEM-1:0] PasoFila = BITS_DIRECCION_MEM'(SUMA_SIG_FILA);
  localparam logic [BITS_DIRECCION_MEM-1:0] PasoCol  = BITS_DIRECCION_MEM'(SUMA_SIG_COLUMNA);

  typedef enum logic [2:0] {
    StReposo  = 3'd0,
    StLeer    = 3'd1,
    StLiberar = 3'd2,
    StLista   = 3'd3,
    StFin     = 3'd4
  } estado_e;

  estado_e                       estado_q, estado_d;
  logic [BITS_DIRECCION_MEM-1:0] dir_q, dir_d;
  logic [BITS_DIRECCION_MEM-1:0] base_q, base_d;
  logic [BitsCarg-1:0]           carg_q, carg_d;
  logic [BitsLeid-1:0]           leid_q, leid_d;
  logic [BitsCol-1:0]            col_q, col_d;
  logic [BitsVen-1:0]            ven_q, ven_d;

  always_comb begin
    estado_d = estado_q;
    dir_d    = dir_q;
    base_d   = base_q;
    carg_d   = carg_q;
    leid_d   = leid_q;
    col_d    = col_q;
    ven_d    = ven_q;
    unique case (estado_q)
      StReposo: begin
        if (iniciar_proceso) begin
          dir_d    = base_q;
          carg_d   = '0;
          leid_d   = '0;
          estado_d = StLeer;
        end
      end
      StLeer: begin
        if (transaccion_mem_completada) begin
          // Oldest row sits in the low slice; new row enters at the top.
          ven_d  = {datos_mem, ven_q[BitsVen-1:BITS_FILA]};
          dir_d  = dir_q + PasoFila;
          leid_d = leid_q + 1'b1;
          if (carg_q != MaxCarg) begin
            carg_d = carg_q + 1'b1;
          end
          estado_d = StLiberar;
        end
      end
      StLiberar: begin
        estado_d = (carg_q < MaxCarg) ? StLeer : StLista;
      end
      StLista: begin
        if (actualizar_ventana) begin
          estado_d = (leid_q < MaxLeid) ? StLeer : StFin;
        end
      end
      StFin: begin
        if (col_q == UltCol) begin
          col_d  = '0;
          base_d = DirIni;
        end else begin
          col_d  = col_q + 1'b1;
          base_d = base_q + PasoCol;
        end
        estado_d = StReposo;
      end
      default: estado_d = StReposo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q <= StReposo;
      dir_q    <= DirIni;
      base_q   <= DirIni;
      carg_q   <= '0;
      leid_q   <= '0;
      col_q    <= '0;
      ven_q    <= '0;
    end else begin
      estado_q <= estado_d;
      dir_q    <= dir_d;
      base_q   <= base_d;
      carg_q   <= carg_d;
      leid_q   <= leid_d;
      col_q    <= col_d;
      ven_q    <= ven_d;
    end
  end

  // Moore outputs decoded straight from registered state.
  assign ventana         = ven_q;
  assign direccion_mem   = dir_q;
  assign leer_mem        = (estado_q == StLeer);
  assign liberar_bus_mem = (estado_q == StLiberar);
  assign ventana_lista   = (estado_q == StLista);
  assign fin_columna     = (estado_q == StFin);
  assign fin_imagen      = (estado_q == StFin) && (col_q == UltCol);

endmodule

// File: tb/tb_manejo_ventana_deslizante.sv
// Bench for manejo_ventana_deslizante: default instance plus a small wrapping-address instance,
// each served by a memory model returning data = address.
module tb_manejo_ventana_deslizante;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  iniciar, actualizar, compl;
  logic [63:0] datos [2];
  wire  [1:0]  leer, lib, lista, finc, fini;
  wire  [16:0] dir0;
  wire  [9:0]  dir1;
  wire  [319:0] ven0, ven1;

  manejo_ventana_deslizante dut0 (
    .clk(clk), .reset(reset), .iniciar_proceso(iniciar[0]), .actualizar_ventana(actualizar[0]),
    .datos_mem(datos[0]), .transaccion_mem_completada(compl[0]), .ventana(ven0),
    .leer_mem(leer[0]), .liberar_bus_mem(lib[0]), .direccion_mem(dir0),
    .ventana_lista(lista[0]), .fin_columna(finc[0]), .fin_imagen(fini[0])
  );

  manejo_ventana_deslizante #(
    .FILAS_IMAGEN(6), .COLUMNAS_IMAGEN(2), .BITS_DIRECCION_MEM(10),
    .DIRECCION_INICIAL(1000), .SUMA_SIG_FILA(16), .SUMA_SIG_COLUMNA(1)
  ) dut1 (
    .clk(clk), .reset(reset), .iniciar_proceso(iniciar[1]), .actualizar_ventana(actualizar[1]),
    .datos_mem(datos[1]), .transaccion_mem_completada(compl[1]), .ventana(ven1),
    .leer_mem(leer[1]), .liberar_bus_mem(lib[1]), .direccion_mem(dir1),
    .ventana_lista(lista[1]), .fin_columna(finc[1]), .fin_imagen(fini[1])
  );

  int n_asserts = 0;
  int n_fallos  = 0;

  // Memory model and reference state.
  int          espera [2];
  int          espera_act [2];
  int          cnt [2];
  bit          espurio [2];
  bit          aleatorio [2];
  bit          inestable [2];
  int          nlib [2];
  logic [16:0] dir_prev [2];
  logic [63:0] q0[$], q1[$];
  logic [16:0] adr0[$], adr1[$];

  function automatic logic [16:0] dir_de(input int i);
    return (i == 0) ? dir0 : {7'b0, dir1};
  endfunction

  function automatic logic [16:0] dir_esp(input int i, input int unsigned col, input int unsigned k);
    if (i == 0) return 17'((col + 256 * k) % (1 << 17));
    return 17'((1000 + col + 16 * k) % 1024);
  endfunction

  // Window = last five rows delivered, oldest in slice 0.
  function automatic logic [319:0] ven_esp(input int i);
    logic [319:0] v;
    int n;
    v = '0;
    if (i == 0) begin
      n = q0.size();
      for (int k = 0; k < 5; k++) v[64*k +: 64] = q0[n-5+k];
    end else begin
      n = q1.size();
      for (int k = 0; k < 5; k++) v[64*k +: 64] = q1[n-5+k];
    end
    return v;
  endfunction

  task automatic modelo_reset(input int i);
    if (i == 0) begin
      q0.delete(); adr0.delete();
      repeat (5) q0.push_back(64'd0);
    end else begin
      q1.delete(); adr1.delete();
      repeat (5) q1.push_back(64'd0);
    end
    nlib[i] = 0; inestable[i] = 1'b0; cnt[i] = 0;
  endtask

  // One clock: advance, then drive memory inputs for the cycle now visible.
  task automatic ciclo();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (leer[i] === 1'b1) begin
        if (cnt[i] == 0) espera_act[i] = aleatorio[i] ? int'($urandom_range(0, 3)) : espera[i];
        else if (dir_de(i) !== dir_prev[i]) inestable[i] = 1'b1;
        dir_prev[i] = dir_de(i);
        if (cnt[i] == espera_act[i]) begin
          compl[i] = 1'b1;
          datos[i] = 64'(dir_de(i));
          cnt[i]   = 0;
          if (i == 0) begin q0.push_back(datos[0]); adr0.push_back(dir_de(0)); end
          else        begin q1.push_back(datos[1]); adr1.push_back(dir_de(1)); end
        end else begin
          compl[i] = 1'b0;
          cnt[i]++;
        end
      end else begin
        cnt[i]   = 0;
        compl[i] = espurio[i] ? 1'($urandom_range(0, 1)) : 1'b0;
        datos[i] = {$urandom, $urandom};
      end
      if (lib[i] === 1'b1) nlib[i]++;
    end
  endtask

  task automatic esperar_lista(input int i, input int t_ini, output int t);
    t = t_ini;
    while (lista[i] !== 1'b1 && t < 200) begin
      ciclo();
      t++;
    end
  endtask

  task automatic pulso_reset();
    reset = 1'b0; compl = '0; iniciar = '0; actualizar = '0;
    ciclo();
    reset = 1'b1;
    compl = '0;
    modelo_reset(0);
    modelo_reset(1);
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = '0; actualizar = '0; compl = '0;
    datos[0] = '0; datos[1] = '0;
    for (int i = 0; i < 2; i++) begin
      espera[i] = 0; espurio[i] = 0; aleatorio[i] = 0; espera_act[i] = 0;
    end
    repeat (2) ciclo();
    n_asserts++;
    if ({leer[0], lib[0], lista[0], finc[0], fini[0]} !== 5'b0) begin
      n_fallos++;
      $display("FAIL reset_salidas0: got %b expected 00000", {leer[0], lib[0], lista[0], finc[0], fini[0]});
    end
    n_asserts++;
    if (dir0 !== 17'd0) begin n_fallos++; $display("FAIL reset_dir0: got %0d expected 0", dir0); end
    n_asserts++;
    if (ven0 !== '0) begin n_fallos++; $display("FAIL reset_ventana0: got %h expected 0", ven0); end
    n_asserts++;
    if ({leer[1], lib[1], lista[1], finc[1], fini[1]} !== 5'b0) begin
      n_fallos++;
      $display("FAIL reset_salidas1: got %b expected 00000", {leer[1], lib[1], lista[1], finc[1], fini[1]});
    end
    n_asserts++;
    if (dir1 !== 10'd1000) begin n_fallos++; $display("FAIL reset_dir1: got %0d expected 1000", dir1); end
    reset = 1'b1;
    modelo_reset(0);
    modelo_reset(1);
  endtask

  task automatic test_fill(input string et);
    int t;
    logic [31:0] mask, mask_esp;
    iniciar[0] = 1'b1;
    ciclo();
    iniciar[0] = 1'b0;
    t = 1; mask = '0; mask_esp = '0;
    while (lista[0] !== 1'b1 && t < 200) begin
      ciclo();
      t++;
      if (lib[0] === 1'b1 && t < 32) mask[t] = 1'b1;
    end
    for (int k = 0; k < 5; k++) mask_esp[2+2*k] = 1'b1;
    n_asserts++;
    if (t != 11) begin n_fallos++; $display("FAIL %s latencia: got %0d expected 11", et, t); end
    n_asserts++;
    if (mask !== mask_esp) begin
      n_fallos++; $display("FAIL %s liberar_ciclos: got %h expected %h", et, mask, mask_esp);
    end
    n_asserts++;
    if (adr0.size() != 5) begin n_fallos++; $display("FAIL %s n_lecturas: got %0d expected 5", et, adr0.size()); end
    for (int k = 0; k < adr0.size() && k < 5; k++) begin
      n_asserts++;
      if (adr0[k] !== dir_esp(0, 0, k)) begin
        n_fallos++; $display("FAIL %s dir%0d: got %0d expected %0d", et, k, adr0[k], dir_esp(0, 0, k));
      end
    end
    n_asserts++;
    if (ven0[63:0] !== 64'd0 || ven0[319:256] !== 64'd1024) begin
      n_fallos++;
      $display("FAIL %s slices: got %0d/%0d expected 0/1024", et, ven0[63:0], ven0[319:256]);
    end
    n_asserts++;
    if (ven0 !== ven_esp(0)) begin n_fallos++; $display("FAIL %s ventana: got %h expected %h", et, ven0, ven_esp(0)); end
  endtask

  task automatic test_slide();
    int t;
    actualizar[0] = 1'b1;
    ciclo();
    actualizar[0] = 1'b0;
    esperar_lista(0, 1, t);
    n_asserts++;
    if (t != 3) begin n_fallos++; $display("FAIL slide_latencia: got %0d expected 3", t); end
    n_asserts++;
    if (adr0.size() != 6 || adr0[adr0.size()-1] !== 17'd1280) begin
      n_fallos++; $display("FAIL slide_dir: got n=%0d last=%0d expected n=6 last=1280", adr0.size(), adr0[adr0.size()-1]);
    end
    n_asserts++;
    if (ven0[63:0] !== 64'd256 || ven0[319:256] !== 64'd1280) begin
      n_fallos++; $display("FAIL slide_slices: got %0d/%0d expected 256/1280", ven0[63:0], ven0[319:256]);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    pulso_reset();
    iniciar[0] = 1'b1;
    ciclo();
    iniciar[0] = 1'b0;
    t = 0;
    while (adr0.size() < 3 && t < 100) begin ciclo(); t++; end
    // A completion is being driven in this cycle; reset lands on the same edge.
    reset = 1'b0;
    ciclo();
    n_asserts++;
    if ({leer[0], lib[0], lista[0], finc[0], fini[0]} !== 5'b0 || dir0 !== 17'd0) begin
      n_fallos++;
      $display("FAIL reset_mid_salidas: got %b dir=%0d expected 00000 dir=0",
               {leer[0], lib[0], lista[0], finc[0], fini[0]}, dir0);
    end
    n_asserts++;
    if (ven0 !== '0) begin n_fallos++; $display("FAIL reset_mid_ventana: got %h expected 0", ven0); end
    reset = 1'b1;
    compl = '0;
    modelo_reset(0);
    modelo_reset(1);
    test_fill("reinicio");
  endtask

  task automatic test_wait();
    int t;
    pulso_reset();
    espera[0] = 3; espurio[0] = 1'b1;
    iniciar[0] = 1'b1;
    ciclo();
    iniciar[0] = 1'b0;
    t = 1;
    while (lista[0] !== 1'b1 && t < 200) begin
      actualizar[0] = 1'($urandom_range(0, 1));
      iniciar[0]    = 1'($urandom_range(0, 1));
      ciclo();
      t++;
    end
    actualizar[0] = 1'b0; iniciar[0] = 1'b0;
    n_asserts++;
    if (t != 26) begin n_fallos++; $display("FAIL espera_latencia: got %0d expected 26", t); end
    n_asserts++;
    if (inestable[0]) begin n_fallos++; $display("FAIL espera_dir_estable: got cambio expected estable"); end
    n_asserts++;
    if (nlib[0] != 5 || adr0.size() != 5) begin
      n_fallos++; $display("FAIL espera_capturas: got lib=%0d lect=%0d expected 5/5", nlib[0], adr0.size());
    end
    n_asserts++;
    if (ven0 !== ven_esp(0)) begin n_fallos++; $display("FAIL espera_ventana: got %h expected %h", ven0, ven_esp(0)); end
    espera[0] = 0; espurio[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t, l0, a0;
    l0 = nlib[0]; a0 = adr0.size();
    actualizar[0] = 1'b1;
    repeat (9) ciclo();
    actualizar[0] = 1'b0;
    esperar_lista(0, 0, t);
    n_asserts++;
    if (nlib[0] - l0 != 3 || adr0.size() - a0 != 3) begin
      n_fallos++;
      $display("FAIL b2b_deslizamientos: got lib=%0d lect=%0d expected 3/3", nlib[0] - l0, adr0.size() - a0);
    end
    n_asserts++;
    if (ven0 !== ven_esp(0)) begin n_fallos++; $display("FAIL b2b_ventana: got %h expected %h", ven0, ven_esp(0)); end
  endtask

  task automatic test_random();
    int t, n;
    espurio[0] = 1'b1; aleatorio[0] = 1'b1;
    n = int'($urandom_range(4, 8));
    for (int s = 0; s < n; s++) begin
      repeat ($urandom_range(0, 3)) ciclo();
      actualizar[0] = 1'b1;
      ciclo();
      actualizar[0] = 1'b0;
      esperar_lista(0, 1, t);
      n_asserts++;
      if (ven0 !== ven_esp(0)) begin
        n_fallos++; $display("FAIL aleatorio_ventana%0d: got %h expected %h", s, ven0, ven_esp(0));
      end
    end
    n_asserts++;
    if (adr0[adr0.size()-1] !== dir_esp(0, 0, adr0.size() - 1)) begin
      n_fallos++;
      $display("FAIL aleatorio_dir: got %0d expected %0d", adr0[adr0.size()-1], dir_esp(0, 0, adr0.size() - 1));
    end
    espurio[0] = 1'b0; aleatorio[0] = 1'b0;
  endtask

  task automatic test_columns();
    int t;
    pulso_reset();
    for (int c = 0; c < 2; c++) begin
      adr1.delete();
      iniciar[1] = 1'b1;
      ciclo();
      iniciar[1] = 1'b0;
      esperar_lista(1, 1, t);
      actualizar[1] = 1'b1;
      ciclo();
      actualizar[1] = 1'b0;
      esperar_lista(1, 1, t);
      n_asserts++;
      if (adr1.size() != 6) begin n_fallos++; $display("FAIL col%0d n_lecturas: got %0d expected 6", c, adr1.size()); end
      for (int k = 0; k < adr1.size() && k < 6; k++) begin
        n_asserts++;
        if (adr1[k] !== dir_esp(1, c, k)) begin
          n_fallos++; $display("FAIL col%0d dir%0d: got %0d expected %0d", c, k, adr1[k], dir_esp(1, c, k));
        end
      end
      n_asserts++;
      if (ven1 !== ven_esp(1)) begin n_fallos++; $display("FAIL col%0d ventana: got %h expected %h", c, ven1, ven_esp(1)); end
      actualizar[1] = 1'b1;
      ciclo();
      actualizar[1] = 1'b0;
      n_asserts++;
      if (finc[1] !== 1'b1 || fini[1] !== (c == 1) || leer[1] !== 1'b0) begin
        n_fallos++;
        $display("FAIL col%0d fin: got finc=%b fini=%b leer=%b expected 1/%0d/0", c, finc[1], fini[1], leer[1], c);
      end
      ciclo();
      n_asserts++;
      if ({leer[1], lista[1], finc[1], fini[1]} !== 4'b0 || adr1.size() != 6) begin
        n_fallos++;
        $display("FAIL col%0d reposo: got %b lect=%0d expected 0000 lect=6",
                 c, {leer[1], lista[1], finc[1], fini[1]}, adr1.size());
      end
    end
    iniciar[1] = 1'b1;
    ciclo();
    iniciar[1] = 1'b0;
    n_asserts++;
    if (leer[1] !== 1'b1 || dir1 !== 10'd1000) begin
      n_fallos++; $display("FAIL imagen_vuelta_base: got leer=%b dir=%0d expected 1/1000", leer[1], dir1);
    end
  endtask

  initial begin
    test_reset();
    test_fill("llenado");
    test_slide();
    test_reset_mid();
    test_wait();
    test_back_to_back();
    test_random();
    test_columns();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fallos);
    $finish;
  end

endmodule
